// File: rtl/rf_pkg.sv
// Shared types and widths for the register-file write arbiter.
package rf_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic {INIT, RUN} rf_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wr_req_t;
endpackage

// File: rtl/rf_wr_fifo.sv
// Small synchronous FIFO holding long-latency-unit write requests.
// Push is ignored when full and pop is ignored when empty, so a pop at full
// only frees space for the following cycle.
module rf_wr_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wr_req_t push_data,
  input  logic    pop,
  output wr_req_t head,
  output logic    full,
  output logic    empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  wr_req_t         mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, the
// long-latency unit is buffered and drained in idle writeback cycles, and a
// starvation counter requests a one-cycle writeback bubble.
// Optional macro RF_CLEAR_EN adds a 32-cycle zeroing sweep after reset.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int LU_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_addr,
  input  logic [XLEN-1:0]       lu_data,
  output logic                  lu_ready,
  output logic                  rf_reg_wr,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  wb_stall,
  output logic                  init_busy
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  rf_state_e     state;
  wr_req_t       lu_req, head;
  logic          full, empty, push, pop, run_st, in_init;
  logic [SW-1:0] starve_cnt;

`ifdef RF_CLEAR_EN
  rf_state_e             state_nxt;
  logic [REG_ADDR_W-1:0] sweep;

  // State register and sweep address; reset always restarts the sweep at 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT;
      sweep <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) sweep <= sweep + REG_ADDR_W'(1);
    end
  end

  // Leave INIT after the last register has been cleared.
  always_comb begin
    state_nxt = state;
    if (state == INIT && sweep == '1) state_nxt = RUN;
  end

  assign in_init   = rst_n && (state == INIT);
  assign init_busy = (state == INIT);
`else
  assign state     = RUN;
  assign in_init   = 1'b0;
  assign init_busy = 1'b0;
`endif

  assign run_st   = rst_n && (state == RUN);
  assign lu_ready = run_st && !full;
  assign push     = lu_valid && lu_ready;
  assign pop      = run_st && !wb_valid && !empty;
  assign lu_req   = '{addr: lu_addr, data: lu_data};

  rf_wr_fifo #(.DEPTH(LU_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (lu_req),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Write-port mux: sweep, then writeback, then buffer head; address 0 is dropped.
  always_comb begin
    rf_reg_wr = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
`ifdef RF_CLEAR_EN
    if (in_init) begin
      rf_reg_wr = 1'b1;
      rf_waddr  = sweep;
    end else
`endif
    if (run_st && wb_valid) begin
      if (wb_addr != '0) begin
        rf_reg_wr = 1'b1;
        rf_waddr  = wb_addr;
        rf_wdata  = wb_data;
      end
    end else if (pop) begin
      if (head.addr != '0) begin
        rf_reg_wr = 1'b1;
        rf_waddr  = head.addr;
        rf_wdata  = head.data;
      end
    end
  end

  // Count cycles the buffer loses to writeback; pulse wb_stall at the limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      wb_stall   <= 1'b0;
    end else begin
      wb_stall <= 1'b0;
      if (pop) begin
        starve_cnt <= '0;
      end else if (run_st && wb_valid && !empty) begin
        if (starve_cnt == SW'(STARVE_LIMIT - 1)) begin
          starve_cnt <= '0;
          wb_stall   <= 1'b1;
        end else begin
          starve_cnt <= starve_cnt + SW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, hand sequences for
// starvation and reset, then randomized traffic against a queue model.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  localparam int LU_DEPTH     = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, lu_valid;
  logic [4:0]  wb_addr, lu_addr;
  logic [31:0] wb_data, lu_data;
  logic        lu_ready, rf_reg_wr, wb_stall, init_busy;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_vec = 0;
  int n_bad = 0;

  rf_write_arbiter #(.LU_DEPTH(LU_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data),
    .lu_ready(lu_ready),
    .rf_reg_wr(rf_reg_wr), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_stall(wb_stall), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic wv; logic [4:0] wa; logic [31:0] wd;
    logic lv; logic [4:0] la; logic [31:0] ld;
    logic ewr; logic [4:0] ea; logic [31:0] ed; logic erdy; logic est;
  } vec_t;

  function automatic vec_t mk(logic wv, logic [4:0] wa, logic [31:0] wd,
                              logic lv, logic [4:0] la, logic [31:0] ld,
                              logic ewr, logic [4:0] ea, logic [31:0] ed,
                              logic erdy, logic est);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.lv = lv; v.la = la; v.ld = ld;
    v.ewr = ewr; v.ea = ea; v.ed = ed; v.erdy = erdy; v.est = est;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at negedge, compare settled outputs before posedge.
  task automatic step(input vec_t v, input string nm);
    @(negedge clk);
    wb_valid = v.wv; wb_addr = v.wa; wb_data = v.wd;
    lu_valid = v.lv; lu_addr = v.la; lu_data = v.ld;
    #2;
    n_vec++;
    if ({rf_reg_wr, rf_waddr, rf_wdata, lu_ready, wb_stall, init_busy} !==
        {v.ewr, v.ea, v.ed, v.erdy, v.est, 1'b0}) begin
      n_bad++;
      $display("FAIL %s: wr/addr/data/rdy/stall/busy got %0b/%0d/%h/%0b/%0b/%0b want %0b/%0d/%h/%0b/%0b/0",
               nm, rf_reg_wr, rf_waddr, rf_wdata, lu_ready, wb_stall, init_busy,
               v.ewr, v.ea, v.ed, v.erdy, v.est);
    end
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    lu_valid = 0; lu_addr = 0; lu_data = 0;
  endtask

  // Expect n sweep cycles writing zero to addresses 0..n-1; wb/lu requests ignored.
  task automatic sweep_check(input int n);
    for (int i = 0; i < n; i++) begin
      wb_valid = 1; wb_addr = 5'd9; wb_data = 32'hFFFF_FFFF;
      lu_valid = 1; lu_addr = 5'd3; lu_data = 32'h1;
      #2;
      chk($sformatf("sweep%0d", i), {rf_reg_wr, rf_waddr, rf_wdata, init_busy, lu_ready},
          {1'b1, 5'(i), 32'h0, 1'b1, 1'b0});
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    #2;
    chk("rst_lu_ready", {63'h0, lu_ready}, 64'h0);
    chk("rst_wb_stall", {63'h0, wb_stall}, 64'h0);
    @(negedge clk);
    rst_n = 1;
`ifdef RF_CLEAR_EN
    sweep_check(32);
    #2;
    chk("sweep_done", {62'h0, init_busy, lu_ready}, {62'h0, 1'b0, 1'b1});
`endif
  endtask

  vec_t      tbl [17];
  wr_req_t   mq [$];
  int        mcnt;
  logic      mstall, prev_stall;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    idle_inputs();

    // wv wa wd            lv la ld            ewr ea ed             rdy st
    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,            1, 5, 32'hDEADBEEF, 1, 0);
    tbl[1]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0,            1, 0);
    tbl[2]  = mk(0, 0, 0,            1, 7, 32'h12345678, 0, 0, 0,            1, 0);
    tbl[3]  = mk(0, 0, 0,            0, 0, 0,            1, 7, 32'h12345678, 1, 0);
    tbl[4]  = mk(1, 3, 32'h33,       1, 7, 32'h12345678, 1, 3, 32'h33,       1, 0);
    tbl[5]  = mk(1, 4, 32'h44,       0, 0, 0,            1, 4, 32'h44,       1, 0);
    tbl[6]  = mk(0, 0, 0,            0, 0, 0,            1, 7, 32'h12345678, 1, 0);
    tbl[7]  = mk(1, 1, 32'h11,       1, 8, 32'h80,       1, 1, 32'h11,       1, 0);
    tbl[8]  = mk(1, 2, 32'h22,       1, 9, 32'h90,       1, 2, 32'h22,       1, 0);
    tbl[9]  = mk(1, 3, 32'h33,       1, 10, 32'hA0,      1, 3, 32'h33,       0, 0);
    tbl[10] = mk(0, 0, 0,            1, 10, 32'hA0,      1, 8, 32'h80,       0, 0);
    tbl[11] = mk(1, 11, 32'hBB,      1, 10, 32'hA0,      1, 11, 32'hBB,      1, 0);
    tbl[12] = mk(0, 0, 0,            0, 0, 0,            1, 9, 32'h90,       0, 0);
    tbl[13] = mk(0, 0, 0,            0, 0, 0,            1, 10, 32'hA0,      1, 0);
    tbl[14] = mk(1, 0, 32'h55,       1, 0, 32'h66,       0, 0, 0,            1, 0);
    tbl[15] = mk(0, 0, 0,            1, 12, 32'hC,       0, 0, 0,            1, 0);
    tbl[16] = mk(0, 0, 0,            0, 0, 0,            1, 12, 32'hC,       1, 0);

    do_reset();

`ifdef RF_CLEAR_EN
    // Reset in the middle of the sweep restarts it from address 0.
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    sweep_check(10);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    sweep_check(32);
    #2;
    chk("resweep_done", {62'h0, init_busy, lu_ready}, {62'h0, 1'b0, 1'b1});
`endif

    for (int i = 0; i < 17; i++) step(tbl[i], $sformatf("tbl%0d", i));

    // Starvation: buffer loses four cycles, bubble pulse, head written in bubble.
    step(mk(1, 1, 32'h101, 1, 13, 32'hD0, 1, 1, 32'h101, 1, 0), "starve0");
    step(mk(1, 2, 32'h102, 0, 0, 0,       1, 2, 32'h102, 1, 0), "starve1");
    step(mk(1, 3, 32'h103, 0, 0, 0,       1, 3, 32'h103, 1, 0), "starve2");
    step(mk(1, 4, 32'h104, 0, 0, 0,       1, 4, 32'h104, 1, 0), "starve3");
    step(mk(1, 5, 32'h105, 0, 0, 0,       1, 5, 32'h105, 1, 0), "starve4");
    step(mk(1, 6, 32'h106, 0, 0, 0,       1, 6, 32'h106, 1, 1), "starve_pulse");
    step(mk(0, 0, 0,       0, 0, 0,       1, 13, 32'hD0, 1, 0), "starve_bubble");
    step(mk(0, 0, 0,       0, 0, 0,       0, 0, 0,       1, 0), "starve_after");

    // Buffered entry is discarded by reset.
    step(mk(1, 2, 32'h202, 1, 14, 32'hE0, 1, 2, 32'h202, 1, 0), "pre_rst_push");
    do_reset();
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "post_rst_empty");

    // Randomized traffic against a queue model of the rules.
    mq.delete();
    mcnt = 0; mstall = 0; prev_stall = 0;
    for (int k = 0; k < 3000; k++) begin
      vec_t    v;
      wr_req_t h;
      logic    popped, starve;
      v.wv = prev_stall ? 1'b0 : ($urandom_range(0, 9) < 6);
      v.wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      v.wd = $urandom;
      v.lv = 1'($urandom_range(0, 1));
      v.la = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      v.ld = $urandom;
      v.erdy = (mq.size() < LU_DEPTH);
      v.est  = mstall;
      v.ewr = 0; v.ea = 0; v.ed = 0;
      popped = 0;
      if (v.wv) begin
        if (v.wa != 0) begin v.ewr = 1; v.ea = v.wa; v.ed = v.wd; end
      end else if (mq.size() > 0) begin
        h = mq[0];
        popped = 1;
        if (h.addr != 0) begin v.ewr = 1; v.ea = h.addr; v.ed = h.data; end
      end
      step(v, $sformatf("rand%0d", k));
      starve = v.wv && (mq.size() > 0);
      if (popped) void'(mq.pop_front());
      if (v.lv && v.erdy) mq.push_back('{addr: v.la, data: v.ld});
      mstall = 0;
      if (popped) mcnt = 0;
      else if (starve) begin
        mcnt++;
        if (mcnt == STARVE_LIMIT) begin mstall = 1; mcnt = 0; end
      end
      prev_stall = v.est;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
